// File: rtl/ama_riscv_id_ex_stage_if.sv
// ID/EX boundary bundle: decoded ID fields and ALU result in, EX operands and
// registered control out. The stage is the slave; decode/ALU side is the master.
interface ama_riscv_id_ex_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             stall_ex;
  logic             flush_ex;
  logic             valid_id;
  logic [XLEN-1:0]  pc_id;
  logic [XLEN-1:0]  rs1_data_id;
  logic [XLEN-1:0]  rs2_data_id;
  logic [XLEN-1:0]  imm_id;
  logic [1:0]       alu_a_sel_fwd_id;
  logic [1:0]       alu_b_sel_fwd_id;
  logic [3:0]       alu_op_id;
  logic [4:0]       rd_id;
  logic             reg_we_id;
  logic [XLEN-1:0]  alu_result_ex;
  logic [XLEN-1:0]  alu_in_a;
  logic [XLEN-1:0]  alu_in_b;
  logic [3:0]       alu_op_ex;
  logic [4:0]       rd_ex;
  logic             reg_we_ex;
  logic             valid_ex;
  logic [XLEN-1:0]  alu_result_mem;
  logic [CNT_W-1:0] fwd_cnt;

  modport master (
    output stall_ex, flush_ex, valid_id, pc_id, rs1_data_id, rs2_data_id, imm_id,
           alu_a_sel_fwd_id, alu_b_sel_fwd_id, alu_op_id, rd_id, reg_we_id, alu_result_ex,
    input  alu_in_a, alu_in_b, alu_op_ex, rd_ex, reg_we_ex, valid_ex, alu_result_mem, fwd_cnt
  );

  modport slave (
    input  stall_ex, flush_ex, valid_id, pc_id, rs1_data_id, rs2_data_id, imm_id,
           alu_a_sel_fwd_id, alu_b_sel_fwd_id, alu_op_id, rd_id, reg_we_id, alu_result_ex,
    output alu_in_a, alu_in_b, alu_op_ex, rd_ex, reg_we_ex, valid_ex, alu_result_mem, fwd_cnt
  );
endinterface

// File: rtl/ama_riscv_id_ex_stage.sv
// ID/EX pipeline register with EX operand muxing, a one-deep ALU result
// register for back-to-back forwarding, and a saturating forward-use counter.
module ama_riscv_id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic                    clk,
  input logic                    rst,
  ama_riscv_id_ex_stage_if.slave bus
);

  localparam logic [1:0] SEL_FWD = 2'd2;

  typedef struct packed {
    logic            valid;
    logic            reg_we;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic [1:0]      sel_a;
    logic [1:0]      sel_b;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
  } ex_pkt_t;

  ex_pkt_t          ex_d, ex_q;
  logic [XLEN-1:0]  res_d, res_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             advance;
  logic             uses_fwd;

  always_comb begin
    ex_d     = ex_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    // A flush retires the EX instruction even while stalled.
    advance  = bus.flush_ex | ~bus.stall_ex;
    uses_fwd = (ex_q.sel_a == SEL_FWD) | (ex_q.sel_b == SEL_FWD);

    if (advance && ex_q.valid) begin
      res_d = bus.alu_result_ex;
      if (uses_fwd && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    if (bus.flush_ex) begin
      ex_d = '0;
    end else if (!bus.stall_ex) begin
      ex_d.valid  = bus.valid_id;
      ex_d.reg_we = bus.reg_we_id & bus.valid_id;
      ex_d.rd     = bus.rd_id;
      ex_d.alu_op = bus.alu_op_id;
      ex_d.sel_a  = bus.alu_a_sel_fwd_id;
      ex_d.sel_b  = bus.alu_b_sel_fwd_id;
      ex_d.pc     = bus.pc_id;
      ex_d.rs1    = bus.rs1_data_id;
      ex_d.rs2    = bus.rs2_data_id;
      ex_d.imm    = bus.imm_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    unique case (ex_q.sel_a)
      2'd0:    bus.alu_in_a = ex_q.rs1;
      2'd1:    bus.alu_in_a = ex_q.pc;
      2'd2:    bus.alu_in_a = res_q;
      default: bus.alu_in_a = '0;
    endcase
    unique case (ex_q.sel_b)
      2'd0:    bus.alu_in_b = ex_q.rs2;
      2'd1:    bus.alu_in_b = ex_q.imm;
      2'd2:    bus.alu_in_b = res_q;
      default: bus.alu_in_b = '0;
    endcase
  end

  assign bus.alu_op_ex      = ex_q.alu_op;
  assign bus.rd_ex          = ex_q.rd;
  assign bus.reg_we_ex      = ex_q.reg_we;
  assign bus.valid_ex       = ex_q.valid;
  assign bus.alu_result_mem = res_q;
  assign bus.fwd_cnt        = cnt_q;

endmodule

// File: tb/tb_ama_riscv_id_ex_stage.sv
// Directed + randomized bench for the ID/EX stage against a behavioural model
// of the in-flight EX instruction, result register and forward counter.
module tb_ama_riscv_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_chk  = 0;

  ama_riscv_id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  ama_riscv_id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // model of what sits in EX
  bit          m_valid, m_we;
  int unsigned m_rd, m_op, m_sa, m_sb, m_pc, m_rs1, m_rs2, m_imm, m_res, m_cnt;

  function automatic int unsigned pick(int unsigned sel, int unsigned x, int unsigned y);
    if (sel == 0) return x;
    if (sel == 1) return y;
    if (sel == 2) return m_res;
    return 0;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    if (rst) begin
      {m_valid, m_we} = '0;
      {m_rd, m_op, m_sa, m_sb, m_pc, m_rs1, m_rs2, m_imm, m_res, m_cnt} = '0;
    end else begin
      if ((bus.flush_ex || !bus.stall_ex) && m_valid) begin
        m_res = bus.alu_result_ex;
        if ((m_sa == 2 || m_sb == 2) && m_cnt < CMAX) m_cnt = m_cnt + 1;
      end
      if (bus.flush_ex) begin
        {m_valid, m_we} = '0;
        {m_rd, m_op, m_sa, m_sb, m_pc, m_rs1, m_rs2, m_imm} = '0;
      end else if (!bus.stall_ex) begin
        m_valid = bus.valid_id;
        m_we    = bus.reg_we_id && bus.valid_id;
        m_rd    = bus.rd_id;
        m_op    = bus.alu_op_id;
        m_sa    = bus.alu_a_sel_fwd_id;
        m_sb    = bus.alu_b_sel_fwd_id;
        m_pc    = bus.pc_id;
        m_rs1   = bus.rs1_data_id;
        m_rs2   = bus.rs2_data_id;
        m_imm   = bus.imm_id;
      end
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".a"},     bus.alu_in_a,       pick(m_sa, m_rs1, m_pc));
    chk({tag, ".b"},     bus.alu_in_b,       pick(m_sb, m_rs2, m_imm));
    chk({tag, ".op"},    bus.alu_op_ex,      m_op);
    chk({tag, ".rd"},    bus.rd_ex,          m_rd);
    chk({tag, ".we"},    bus.reg_we_ex,      m_we);
    chk({tag, ".valid"}, bus.valid_ex,       m_valid);
    chk({tag, ".res"},   bus.alu_result_mem, m_res);
    chk({tag, ".cnt"},   bus.fwd_cnt,        m_cnt);
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic rand_id();
    bus.valid_id         = 1'($urandom);
    bus.reg_we_id        = 1'($urandom);
    bus.rd_id            = 5'($urandom);
    bus.alu_op_id        = 4'($urandom);
    bus.alu_a_sel_fwd_id = 2'($urandom);
    bus.alu_b_sel_fwd_id = 2'($urandom);
    bus.pc_id            = $urandom;
    bus.rs1_data_id      = $urandom;
    bus.rs2_data_id      = $urandom;
    bus.imm_id           = $urandom;
    bus.alu_result_ex    = $urandom;
  endtask

  task automatic set_id(bit v, bit we, logic [4:0] rd, logic [1:0] sa, logic [1:0] sb,
                        logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2, logic [31:0] imm);
    bus.valid_id = v;  bus.reg_we_id = we; bus.rd_id = rd; bus.alu_op_id = 4'($urandom);
    bus.alu_a_sel_fwd_id = sa; bus.alu_b_sel_fwd_id = sb;
    bus.pc_id = pc; bus.rs1_data_id = rs1; bus.rs2_data_id = rs2; bus.imm_id = imm;
  endtask

  int unsigned s_a, s_b, s_rd, s_res, s_cnt;
  logic [4:0]  pend_rd;

  initial begin
    bus.stall_ex = 0; bus.flush_ex = 0;
    rand_id();

    // reset with random inputs
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      rand_id();
      bus.stall_ex = 1'($urandom); bus.flush_ex = 1'($urandom);
      tick("rst");
    end
    chk("rst.a0", bus.alu_in_a, 0);
    chk("rst.valid0", bus.valid_ex, 0);
    chk("rst.cnt0", bus.fwd_cnt, 0);
    rst = 0; bus.stall_ex = 0; bus.flush_ex = 0;

    // back-to-back forward: I1 then dependent I2
    set_id(1, 1, 5'd5, 2'd0, 2'd0, 32'h40, 32'h7, 32'h8, 32'h9);
    tick("i1");
    chk("i1.rd", bus.rd_ex, 5);
    chk("i1.valid", bus.valid_ex, 1);
    set_id(1, 1, 5'd6, 2'd2, 2'd1, 32'h44, 32'h0, 32'h0, 32'h10);
    bus.alu_result_ex = 32'h1234;
    tick("i2");
    chk("fwd.a", bus.alu_in_a, 32'h1234);
    chk("fwd.b", bus.alu_in_b, 32'h10);
    set_id(1, 0, 5'd0, 2'd0, 2'd0, 32'h48, 32'h1, 32'h2, 32'h3);
    bus.alu_result_ex = 32'h55;
    tick("i3");
    chk("fwd.cnt", bus.fwd_cnt, 1);
    chk("fwd.res", bus.alu_result_mem, 32'h55);

    // select sweep on both operands
    for (int s = 0; s < 4; s++) begin
      if (s == 2) continue;
      set_id(1, 1, 5'd1, 2'(s), 2'(s), 32'h100, 32'hA, 32'hB, 32'hC);
      tick("sel");
      chk("sel.a", bus.alu_in_a, (s == 0) ? 32'hA : (s == 1) ? 32'h100 : 32'h0);
      chk("sel.b", bus.alu_in_b, (s == 0) ? 32'hB : (s == 1) ? 32'hC : 32'h0);
    end

    // stall 3 cycles with changing ID inputs
    set_id(1, 1, 5'd9, 2'd2, 2'd0, 32'h200, 32'h11, 32'h22, 32'h33);
    tick("pre_stall");
    s_a = pick(m_sa, m_rs1, m_pc); s_b = pick(m_sb, m_rs2, m_imm);
    s_rd = m_rd; s_res = m_res; s_cnt = m_cnt;
    bus.stall_ex = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick("stall");
      chk("stall.a", bus.alu_in_a, s_a);
      chk("stall.b", bus.alu_in_b, s_b);
      chk("stall.rd", bus.rd_ex, s_rd);
      chk("stall.res", bus.alu_result_mem, s_res);
      chk("stall.cnt", bus.fwd_cnt, s_cnt);
    end
    pend_rd = bus.rd_id;
    bus.stall_ex = 0;
    tick("unstall");
    chk("unstall.rd", bus.rd_ex, pend_rd);
    chk("unstall.cnt", bus.fwd_cnt, (s_cnt < CMAX) ? s_cnt + 1 : s_cnt);

    // flush together with stall; make sure a valid instruction is in EX first
    set_id(1, 1, 5'd3, 2'd0, 2'd1, 32'h300, 32'h1, 32'h2, 32'h3);
    tick("pre_flush");
    set_id(1, 1, 5'd4, 2'd0, 2'd0, 32'h304, 32'h5, 32'h6, 32'h7);
    bus.stall_ex = 1; bus.flush_ex = 1; bus.alu_result_ex = 32'hCAFE;
    tick("flush");
    chk("flush.valid", bus.valid_ex, 0);
    chk("flush.we", bus.reg_we_ex, 0);
    chk("flush.a", bus.alu_in_a, 0);
    chk("flush.b", bus.alu_in_b, 0);
    chk("flush.res", bus.alu_result_mem, 32'hCAFE);
    bus.stall_ex = 0; bus.flush_ex = 0;

    // counter saturation: 20 forwarding instructions back to back
    for (int i = 0; i < 20; i++) begin
      set_id(1, 1, 5'(i), 2'd2, 2'(i % 3), $urandom, $urandom, $urandom, $urandom);
      bus.alu_result_ex = $urandom;
      tick("sat");
    end
    chk("sat.cnt", bus.fwd_cnt, CMAX);
    tick("sat2");
    chk("sat.hold", bus.fwd_cnt, CMAX);

    // randomized traffic including occasional reset
    for (int i = 0; i < 300; i++) begin
      rand_id();
      bus.stall_ex = ($urandom_range(3) == 0);
      bus.flush_ex = ($urandom_range(9) == 0);
      rst          = ($urandom_range(99) == 0);
      tick("rnd");
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
